// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-port 32-bit memory shared by fetch and load/store.
// Data wins arbitration unless fetch has waited cMaxDataBurst data grants.
// Ports:
//   iClk, iRst (async, active-high), iFlush
//   fetch: iFetchReq/iFetchAddr -> oFetchGnt/oFetchRdv/oFetchData
//   data:  iDataReq/iDataWe/iDataOpType/iDataAddr/iDataWData
//          -> oDataGnt/oDataRdv/oDataRData/oDataErr
//   mem:   oMemEn/oMemWe/oMemAddr/oMemBe/oMemWData <- iMemAck/iMemRData
module mem_port_arbiter #(
  parameter int cXLEN         = 32,
  parameter int cMaxDataBurst = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iFlush,
  input  logic             iFetchReq,
  input  logic [cXLEN-1:0] iFetchAddr,
  output logic             oFetchGnt,
  output logic             oFetchRdv,
  output logic [cXLEN-1:0] oFetchData,
  input  logic             iDataReq,
  input  logic             iDataWe,
  input  logic [2:0]       iDataOpType,
  input  logic [cXLEN-1:0] iDataAddr,
  input  logic [cXLEN-1:0] iDataWData,
  output logic             oDataGnt,
  output logic             oDataRdv,
  output logic [cXLEN-1:0] oDataRData,
  output logic             oDataErr,
  output logic             oMemEn,
  output logic             oMemWe,
  output logic [cXLEN-1:0] oMemAddr,
  output logic [3:0]       oMemBe,
  output logic [cXLEN-1:0] oMemWData,
  input  logic             iMemAck,
  input  logic [cXLEN-1:0] iMemRData
);

  localparam int cCntW = $clog2(cMaxDataBurst + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH_WAIT,
    DATA_WAIT
  } state_t;

  state_t state_q, state_d;
  logic [cCntW-1:0] cnt_q, cnt_d;
  logic drop_q, drop_d;
  logic [1:0] a_q, a_d;
  logic [2:0] op_q, op_d;
  logic we_q, we_d;

  logic fGnt_q, fGnt_d, fRdv_q, fRdv_d;
  logic [cXLEN-1:0] fData_q, fData_d;
  logic dGnt_q, dGnt_d, dRdv_q, dRdv_d;
  logic dErr_q, dErr_d;
  logic [cXLEN-1:0] dRData_q, dRData_d;
  logic memEn_q, memEn_d, memWe_q, memWe_d;
  logic [cXLEN-1:0] memAddr_q, memAddr_d;
  logic [3:0] memBe_q, memBe_d;
  logic [cXLEN-1:0] memWData_q, memWData_d;

  logic unused;
  assign unused = ^iFetchAddr[1:0];

  // Request decode
  logic [1:0] a, sz;
  logic legal, misal, illegal;
  logic [3:0] be;
  logic [cXLEN-1:0] wrep;

  assign a  = iDataAddr[1:0];
  assign sz = iDataOpType[1:0];
  assign legal = (sz != 2'b11) &&
                 !(iDataOpType[2] && (iDataWe || iDataOpType[1]));
  assign misal = ((sz == 2'b01) && a[0]) ||
                 ((sz == 2'b10) && (a != 2'b00));
  assign illegal = !legal || misal;

  always_comb begin
    be   = 4'hF;
    wrep = iDataWData;
    unique case (sz)
      2'b00: begin
        be   = 4'b0001 << a;
        wrep = {4{iDataWData[7:0]}};
      end
      2'b01: begin
        be   = 4'b0011 << a;
        wrep = {2{iDataWData[15:0]}};
      end
      default: ;
    endcase
  end

  // Load alignment against the captured address/opType
  logic [cXLEN-1:0] sh, ld;
  assign sh = iMemRData >> {a_q, 3'b000};

  always_comb begin
    ld = sh;
    unique case (op_q[1:0])
      2'b00: ld = {{24{sh[7] & ~op_q[2]}}, sh[7:0]};
      2'b01: ld = {{16{sh[15] & ~op_q[2]}}, sh[15:0]};
      default: ;
    endcase
  end

  // Arbitration. A data request still high in its own grant
  // cycle (illegal access, answered from IDLE) is ignored.
  logic dReq, fSel, dSel, sat;
  assign sat  = (cnt_q == cCntW'(cMaxDataBurst));
  assign dReq = iDataReq && !dGnt_q;
  assign fSel = iFetchReq && (!dReq || sat);
  assign dSel = dReq && !fSel;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    a_d        = a_q;
    op_d       = op_q;
    we_d       = we_q;
    fGnt_d     = 1'b0;
    fRdv_d     = 1'b0;
    fData_d    = fData_q;
    dGnt_d     = 1'b0;
    dRdv_d     = 1'b0;
    dErr_d     = 1'b0;
    dRData_d   = dRData_q;
    memEn_d    = memEn_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memBe_d    = memBe_q;
    memWData_d = memWData_q;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (!iFetchReq) cnt_d = '0;
        if (fSel) begin
          cnt_d      = '0;
          state_d    = FETCH_WAIT;
          fGnt_d     = 1'b1;
          memEn_d    = 1'b1;
          memWe_d    = 1'b0;
          memAddr_d  = {iFetchAddr[cXLEN-1:2], 2'b00};
          memBe_d    = 4'hF;
          memWData_d = '0;
        end else if (dSel) begin
          dGnt_d = 1'b1;
          if (iFetchReq && !sat) cnt_d = cnt_q + 1'b1;
          if (illegal) begin
            dRdv_d   = 1'b1;
            dErr_d   = 1'b1;
            dRData_d = '0;
          end else begin
            state_d    = DATA_WAIT;
            memEn_d    = 1'b1;
            memWe_d    = iDataWe;
            memAddr_d  = {iDataAddr[cXLEN-1:2], 2'b00};
            memBe_d    = be;
            memWData_d = wrep;
            a_d        = a;
            op_d       = iDataOpType;
            we_d       = iDataWe;
          end
        end
      end
      FETCH_WAIT: begin
        drop_d = drop_q | iFlush;
        if (iMemAck) begin
          state_d = IDLE;
          memEn_d = 1'b0;
          drop_d  = 1'b0;
          if (!(drop_q || iFlush)) begin
            fRdv_d  = 1'b1;
            fData_d = iMemRData;
          end
        end
      end
      DATA_WAIT: begin
        if (iMemAck) begin
          state_d  = IDLE;
          memEn_d  = 1'b0;
          dRdv_d   = 1'b1;
          dRData_d = we_q ? '0 : ld;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      a_q        <= '0;
      op_q       <= '0;
      we_q       <= 1'b0;
      fGnt_q     <= 1'b0;
      fRdv_q     <= 1'b0;
      fData_q    <= '0;
      dGnt_q     <= 1'b0;
      dRdv_q     <= 1'b0;
      dErr_q     <= 1'b0;
      dRData_q   <= '0;
      memEn_q    <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memBe_q    <= '0;
      memWData_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      a_q        <= a_d;
      op_q       <= op_d;
      we_q       <= we_d;
      fGnt_q     <= fGnt_d;
      fRdv_q     <= fRdv_d;
      fData_q    <= fData_d;
      dGnt_q     <= dGnt_d;
      dRdv_q     <= dRdv_d;
      dErr_q     <= dErr_d;
      dRData_q   <= dRData_d;
      memEn_q    <= memEn_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memBe_q    <= memBe_d;
      memWData_q <= memWData_d;
    end
  end

  assign oFetchGnt  = fGnt_q;
  assign oFetchRdv  = fRdv_q;
  assign oFetchData = fData_q;
  assign oDataGnt   = dGnt_q;
  assign oDataRdv   = dRdv_q;
  assign oDataRData = dRData_q;
  assign oDataErr   = dErr_q;
  assign oMemEn     = memEn_q;
  assign oMemWe     = memWe_q;
  assign oMemAddr   = memAddr_q;
  assign oMemBe     = memBe_q;
  assign oMemWData  = memWData_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed requests, a memory responder,
// and a scoreboard monitor that checks every grant/rdv/memory request.
module tb_mem_port_arbiter;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iFlush;
  logic        iFetchReq;
  logic [31:0] iFetchAddr;
  logic        oFetchGnt, oFetchRdv;
  logic [31:0] oFetchData;
  logic        iDataReq, iDataWe;
  logic [2:0]  iDataOpType;
  logic [31:0] iDataAddr, iDataWData;
  logic        oDataGnt, oDataRdv, oDataErr;
  logic [31:0] oDataRData;
  logic        oMemEn, oMemWe;
  logic [31:0] oMemAddr, oMemWData;
  logic [3:0]  oMemBe;
  logic        iMemAck;
  logic [31:0] iMemRData;

  always #5 iClk = ~iClk;

  mem_port_arbiter #(.cXLEN(32), .cMaxDataBurst(4)) dut (
    .iClk(iClk), .iRst(iRst), .iFlush(iFlush),
    .iFetchReq(iFetchReq), .iFetchAddr(iFetchAddr),
    .oFetchGnt(oFetchGnt), .oFetchRdv(oFetchRdv),
    .oFetchData(oFetchData),
    .iDataReq(iDataReq), .iDataWe(iDataWe),
    .iDataOpType(iDataOpType), .iDataAddr(iDataAddr),
    .iDataWData(iDataWData),
    .oDataGnt(oDataGnt), .oDataRdv(oDataRdv),
    .oDataRData(oDataRData), .oDataErr(oDataErr),
    .oMemEn(oMemEn), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
    .oMemBe(oMemBe), .oMemWData(oMemWData),
    .iMemAck(iMemAck), .iMemRData(iMemRData)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        chk_wd;
  } mreq_t;

  byte         exp_gnt[$];
  logic [31:0] exp_frdv[$];
  logic [32:0] exp_drdv[$];
  mreq_t       exp_mem[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 0;
  logic [31:0] mem_rd = '0;

  int fgnt_cyc, frdv_cyc, dgnt_cyc, drdv_cyc;
  int men_rise_cyc, men_fall_cyc, men_rises, men_falls;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask

  // Memory responder: ack lat cycles after oMemEn rises.
  initial begin
    int acnt;
    acnt = 0;
    iMemAck = 1'b0;
    iMemRData = '0;
    forever begin
      @(negedge iClk);
      if (oMemEn && !iMemAck) begin
        if (acnt == lat) begin
          iMemAck = 1'b1;
          iMemRData = mem_rd;
          acnt = 0;
        end else begin
          acnt++;
        end
      end else begin
        iMemAck = 1'b0;
        acnt = 0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    logic prev_en;
    byte g;
    mreq_t m;
    prev_en = 1'b0;
    men_rises = 0;
    men_falls = 0;
    forever begin
      @(negedge iClk);
      if (oFetchGnt) begin
        fgnt_cyc = cyc;
        if (exp_gnt.size() == 0) timeout("unexpected fetch gnt");
        else begin
          g = exp_gnt.pop_front();
          check("gnt order F", {152'd0, 8'("F")}, {152'd0, g});
        end
      end
      if (oDataGnt) begin
        dgnt_cyc = cyc;
        if (exp_gnt.size() == 0) timeout("unexpected data gnt");
        else begin
          g = exp_gnt.pop_front();
          check("gnt order D", {152'd0, 8'("D")}, {152'd0, g});
        end
      end
      if (oFetchRdv) begin
        frdv_cyc = cyc;
        if (exp_frdv.size() == 0) timeout("unexpected fetch rdv");
        else check("fetch data", 160'(oFetchData),
                   160'(exp_frdv.pop_front()));
      end
      if (oDataRdv) begin
        drdv_cyc = cyc;
        if (exp_drdv.size() == 0) timeout("unexpected data rdv");
        else check("data err/rdata", 160'({oDataErr, oDataRData}),
                   160'(exp_drdv.pop_front()));
      end
      if (oMemEn && !prev_en) begin
        men_rise_cyc = cyc;
        men_rises++;
        if (exp_mem.size() == 0) timeout("unexpected mem req");
        else begin
          m = exp_mem.pop_front();
          check("mem we/addr/be", 160'({oMemWe, oMemAddr, oMemBe}),
                160'({m.we, m.addr, m.be}));
          if (m.chk_wd) check("mem wdata", 160'(oMemWData), 160'(m.wd));
        end
      end
      if (!oMemEn && prev_en) begin
        men_fall_cyc = cyc;
        men_falls++;
      end
      prev_en = oMemEn;
    end
  end

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 60; i++) begin
      if (!oMemEn) break;
      @(posedge iClk); #1;
    end
    if (i == 60) timeout(name);
    repeat (2) @(posedge iClk);
  endtask

  task automatic do_fetch(input logic [31:0] addr, output int req_cyc,
                          input logic flush);
    int i;
    @(negedge iClk);
    iFetchReq = 1'b1;
    iFetchAddr = addr;
    req_cyc = cyc;
    for (i = 0; i < 50; i++) begin
      @(posedge iClk); #1;
      if (oFetchGnt) break;
    end
    iFetchReq = 1'b0;
    if (i == 50) timeout("fetch gnt");
    if (flush) begin
      iFlush = 1'b1;
      @(posedge iClk); #1;
      iFlush = 1'b0;
    end
    wait_idle("fetch done");
  endtask

  task automatic do_data(input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic wait_done);
    int i;
    @(negedge iClk);
    iDataReq = 1'b1;
    iDataWe = we;
    iDataOpType = op;
    iDataAddr = addr;
    iDataWData = wd;
    for (i = 0; i < 50; i++) begin
      @(posedge iClk); #1;
      if (oDataGnt) break;
    end
    iDataReq = 1'b0;
    if (i == 50) timeout("data gnt");
    if (wait_done) wait_idle("data done");
  endtask

  task automatic exp_load(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] waddr, input logic [3:0] be,
                          input logic [31:0] data);
    exp_gnt.push_back("D");
    exp_mem.push_back('{1'b0, waddr, be, 32'd0, 1'b0});
    exp_drdv.push_back({1'b0, data});
    do_data(1'b0, op, addr, 32'd0, 1'b1);
  endtask

  task automatic exp_store(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] waddr,
                           input logic [3:0] be, input logic [31:0] mwd);
    exp_gnt.push_back("D");
    exp_mem.push_back('{1'b1, waddr, be, mwd, 1'b1});
    exp_drdv.push_back({1'b0, 32'd0});
    do_data(1'b1, op, addr, wd, 1'b1);
  endtask

  task automatic exp_illegal(input logic we, input logic [2:0] op,
                             input logic [31:0] addr);
    int r0;
    r0 = men_rises;
    exp_gnt.push_back("D");
    exp_drdv.push_back({1'b1, 32'd0});
    do_data(we, op, addr, 32'h11223344, 1'b1);
    check("illegal gnt==rdv cycle", 160'(dgnt_cyc), 160'(drdv_cyc));
    check("illegal no mem", 160'(men_rises), 160'(r0));
  endtask

  initial begin
    int rc, n, r0, f0;
    iRst = 1'b1;
    iFlush = 1'b0;
    iFetchReq = 1'b0;
    iFetchAddr = '0;
    iDataReq = 1'b0;
    iDataWe = 1'b0;
    iDataOpType = '0;
    iDataAddr = '0;
    iDataWData = '0;
    repeat (3) @(posedge iClk);
    #1;
    check("reset outputs",
          160'({oFetchGnt, oFetchRdv, oFetchData, oDataGnt, oDataRdv,
                oDataRData, oDataErr, oMemEn, oMemWe, oMemAddr, oMemBe,
                oMemWData}), 160'd0);
    @(negedge iClk);
    iRst = 1'b0;
    repeat (2) @(posedge iClk);

    // Lone fetch, ack 2 cycles after oMemEn rises
    lat = 2;
    mem_rd = 32'h12345678;
    exp_gnt.push_back("F");
    exp_mem.push_back('{1'b0, 32'h100, 4'hF, 32'd0, 1'b0});
    exp_frdv.push_back(32'h12345678);
    do_fetch(32'h100, rc, 1'b0);
    check("fetch gnt latency", 160'(fgnt_cyc - rc), 160'd1);
    check("memEn rise with gnt", 160'(men_rise_cyc), 160'(fgnt_cyc));
    check("memEn 3 cycles", 160'(men_fall_cyc - men_rise_cyc), 160'd3);
    check("fetch rdv cycle 4", 160'(frdv_cyc - fgnt_cyc), 160'd3);

    // Loads of 0xAABBCCDD
    lat = 1;
    mem_rd = 32'hAABBCCDD;
    exp_load(3'b000, 32'h203, 32'h200, 4'b1000, 32'hFFFFFFAA);
    exp_load(3'b100, 32'h203, 32'h200, 4'b1000, 32'h000000AA);
    exp_load(3'b001, 32'h202, 32'h200, 4'b1100, 32'hFFFFAABB);
    exp_load(3'b101, 32'h200, 32'h200, 4'b0011, 32'h0000CCDD);
    exp_load(3'b000, 32'h201, 32'h200, 4'b0010, 32'hFFFFFFCC);
    exp_load(3'b100, 32'h200, 32'h200, 4'b0001, 32'h000000DD);
    lat = 0;
    exp_load(3'b010, 32'h204, 32'h204, 4'hF, 32'hAABBCCDD);

    // Stores
    exp_store(3'b001, 32'h102, 32'h0000BEEF, 32'h100, 4'b1100,
              32'hBEEFBEEF);
    exp_store(3'b000, 32'h101, 32'h123456A5, 32'h100, 4'b0010,
              32'hA5A5A5A5);
    exp_store(3'b010, 32'h108, 32'hDEADBEEF, 32'h108, 4'hF,
              32'hDEADBEEF);

    // Illegal / misaligned
    exp_illegal(1'b0, 3'b010, 32'h101);
    exp_illegal(1'b1, 3'b001, 32'h103);
    exp_illegal(1'b0, 3'b011, 32'h100);
    exp_illegal(1'b1, 3'b100, 32'h100);

    // Both requesting, 1-cycle acks: D,D,D,D,F,D,D,D,D,F
    lat = 0;
    mem_rd = 32'h0BADF00D;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) begin
        exp_gnt.push_back("F");
        exp_mem.push_back('{1'b0, 32'h300, 4'hF, 32'd0, 1'b0});
        exp_frdv.push_back(32'h0BADF00D);
      end else begin
        exp_gnt.push_back("D");
        exp_mem.push_back('{1'b0, 32'h0, 4'hF, 32'd0, 1'b0});
        exp_drdv.push_back({1'b0, 32'h0BADF00D});
      end
    end
    @(negedge iClk);
    iFetchReq = 1'b1;
    iFetchAddr = 32'h300;
    iDataReq = 1'b1;
    iDataWe = 1'b0;
    iDataOpType = 3'b010;
    iDataAddr = 32'h0;
    n = 0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(posedge iClk); #1;
      if (oFetchGnt) n++;
      if (oDataGnt) n++;
    end
    iFetchReq = 1'b0;
    iDataReq = 1'b0;
    if (n < 10) timeout("burst grants");
    wait_idle("burst done");

    // Flush during FETCH_WAIT drops the response
    lat = 2;
    mem_rd = 32'hCAFEF00D;
    f0 = men_falls;
    exp_gnt.push_back("F");
    exp_mem.push_back('{1'b0, 32'h400, 4'hF, 32'd0, 1'b0});
    do_fetch(32'h400, rc, 1'b1);
    check("flushed fetch completes", 160'(men_falls - f0), 160'd1);
    mem_rd = 32'h00C0FFEE;
    exp_gnt.push_back("F");
    exp_mem.push_back('{1'b0, 32'h404, 4'hF, 32'd0, 1'b0});
    exp_frdv.push_back(32'h00C0FFEE);
    do_fetch(32'h404, rc, 1'b0);

    // Reset in DATA_WAIT abandons the access
    lat = 20;
    r0 = men_rises;
    exp_gnt.push_back("D");
    exp_mem.push_back('{1'b1, 32'h500, 4'hF, 32'h01020304, 1'b1});
    do_data(1'b1, 3'b010, 32'h500, 32'h01020304, 1'b0);
    repeat (2) @(posedge iClk);
    #3;
    check("memEn before reset", 160'(oMemEn), 160'd1);
    iRst = 1'b1;
    #1;
    check("memEn cleared async", 160'(oMemEn), 160'd0);
    check("no rdv on reset", 160'(oDataRdv), 160'd0);
    @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    repeat (4) @(posedge iClk);
    check("one mem req in reset test", 160'(men_rises - r0), 160'd1);

    check("gnt queue empty", 160'(exp_gnt.size()), 160'd0);
    check("fetch rdv queue empty", 160'(exp_frdv.size()), 160'd0);
    check("data rdv queue empty", 160'(exp_drdv.size()), 160'd0);
    check("mem queue empty", 160'(exp_mem.size()), 160'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
